irq_request_latch: RTL and testbench

//   Captures rising edges on N asynchronous-free (already synchronous) request lines into a pending register.

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_request_latch_if.sv | 16 +
 rtl/irq_request_latch_prio_sel.sv | 25 ++
 rtl/irq_request_latch.sv | 114 +++++++++++
 tb/tb_irq_request_latch.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and sizing helpers for the IRQ request latch.
package irq_pkg;

    localparam int unsigned N_DEFAULT = 8;

    function automatic int unsigned code_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CODE_W_DEFAULT = code_width(N_DEFAULT);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/irq_request_latch_if.sv
// Valid/ready code handshake between the request latch and its consumer.
interface irq_request_latch_if
    import irq_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
);
    localparam int unsigned CODE_W = code_width(N);

    logic              code_valid;
    logic              code_ready;
    logic [CODE_W-1:0] code;

    modport master (output code_valid, output code, input code_ready);
    modport slave  (input code_valid, input code, output code_ready);

endinterface

// File: rtl/irq_request_latch_prio_sel.sv
// Combinational MSB-first priority select with an any-bit-set flag.
module pend_prio_sel
    import irq_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    localparam int unsigned CODE_W = code_width(N)
) (
    input  logic [N-1:0]      vec,
    output logic [CODE_W-1:0] code,
    output logic              any
);

    always_comb begin
        code = '0;
        any  = 1'b0;
        // Ascending scan: the last hit is the highest set index.
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) begin
                code = CODE_W'(i);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_request_latch.sv
// Rising-edge request latch with mask and MSB-priority code handshake.
// Optional sticky overflow flag enabled by defining PEND_OVERFLOW_EN.
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_in,
    input  logic [N-1:0]         mask,
    input  logic                 clr_all,
    irq_request_latch_if.master  code_if,
    output logic [N-1:0]         pending,
    output logic                 overflow
);

    localparam int unsigned CODE_W = code_width(N);

    state_e            state_q, state_d;
    logic [N-1:0]      req_d_q;
    logic [N-1:0]      pending_q, pending_d;
    logic              code_valid_q, code_valid_d;
    logic [CODE_W-1:0] code_q, code_d;

    logic [N-1:0]      edge_vec;
    logic [N-1:0]      ack_vec;
    logic [N-1:0]      eligible;
    logic              accept;
    logic [CODE_W-1:0] sel_code;
    logic              sel_any;

    pend_prio_sel #(.N(N)) u_sel (
        .vec  (eligible),
        .code (sel_code),
        .any  (sel_any)
    );

    always_comb begin
        edge_vec = req_in & ~req_d_q;
        accept   = code_valid_q & code_if.code_ready;
        ack_vec  = '0;
        if (accept) begin
            ack_vec[code_q] = 1'b1;
        end
        // A new edge re-arms a bit even when its old request is being acknowledged.
        pending_d = clr_all ? '0 : ((pending_q & ~ack_vec) | edge_vec);
        eligible  = pending_q & ~mask;

        state_d      = state_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (!clr_all && sel_any) begin
                    code_d       = sel_code;
                    code_valid_d = 1'b1;
                    state_d      = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (clr_all || accept) begin
                    code_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                code_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        req_d_q <= req_in;
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            code_valid_q <= 1'b0;
            code_q       <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            code_valid_q <= code_valid_d;
            code_q       <= code_d;
        end
    end

`ifdef PEND_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = clr_all ? 1'b0
                             : (overflow_q | (|(edge_vec & pending_q & ~ack_vec)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign pending            = pending_q;
    assign code_if.code_valid = code_valid_q;
    assign code_if.code       = code_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Self-checking bench for irq_request_latch: directed scenarios plus random run vs a reference model.
module tb_irq_request_latch;

    localparam int N = 8;
`ifdef PEND_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_in;
    logic [N-1:0] mask;
    logic         clr_all;
    logic [N-1:0] pending;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit [N-1:0] m_pend;
    bit [N-1:0] m_prev_req;
    bit         m_valid;
    int         m_code;
    bit         m_ovf;

    irq_request_latch_if #(.N(N)) cif ();

    irq_request_latch #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .mask     (mask),
        .clr_all  (clr_all),
        .code_if  (cif.master),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Spec-level model: one call per rising clock edge, using inputs stable at that edge.
    task automatic model_step();
        bit [N-1:0] nxt;
        bit         acc;
        bit         hit;
        int         best;
        if (!rst_n) begin
            m_pend = '0; m_valid = 1'b0; m_code = 0; m_ovf = 1'b0;
            m_prev_req = req_in;
            return;
        end
        acc = m_valid && cif.code_ready;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            bit rose;
            bit acked;
            rose  = req_in[i] && !m_prev_req[i];
            acked = acc && (m_code == i);
            if (clr_all)     nxt[i] = 1'b0;
            else if (rose)   nxt[i] = 1'b1;
            else if (acked)  nxt[i] = 1'b0;
            else             nxt[i] = m_pend[i];
            if (rose && m_pend[i] && !acked) hit = 1'b1;
        end
        if (OVF_EN) begin
            if (clr_all) m_ovf = 1'b0;
            else if (hit) m_ovf = 1'b1;
        end
        if (m_valid) begin
            if (clr_all || acc) m_valid = 1'b0;
        end else if (!clr_all) begin
            best = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (best < 0 && m_pend[i] && !mask[i]) best = i;
            end
            if (best >= 0) begin
                m_valid = 1'b1;
                m_code  = best;
            end
        end
        m_pend     = nxt;
        m_prev_req = req_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_in = '0; mask = '0; clr_all = 1'b0; cif.code_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = 8'h01; mask = '0; clr_all = 1'b0; cif.code_ready = 1'b1;
        tick(); tick();
        checks++;
        if (cif.code_valid !== 1'b0 || cif.code !== 3'd0 || pending !== 8'h00 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b code=%0d pending=%h ovf=%b, want 0/0/00/0",
                     cif.code_valid, cif.code, pending, overflow);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (cif.code_valid !== 1'b0 || pending !== 8'h00) begin
                errors++;
                $display("FAIL reset_held_req cyc%0d: valid=%b pending=%h, want 0/00",
                         c, cif.code_valid, pending);
            end
        end
        req_in = '0;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        cif.code_ready = 1'b1;
        req_in = 8'h04;
        tick();
        checks++;
        if (pending !== 8'h04 || cif.code_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latch: pending=%h valid=%b, want 04/0", pending, cif.code_valid);
        end
        tick();
        checks++;
        if (cif.code_valid !== 1'b1 || cif.code !== 3'd2) begin
            errors++;
            $display("FAIL single_present: valid=%b code=%0d, want 1/2", cif.code_valid, cif.code);
        end
        tick();
        checks++;
        if (cif.code_valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL single_accept: valid=%b pending=%h, want 0/00", cif.code_valid, pending);
        end
        req_in = '0;
        tick();
    endtask

    task automatic test_two_edges();
        logic [2:0] want_code [2];
        apply_reset();
        want_code[0] = 3'd5; want_code[1] = 3'd0;
        cif.code_ready = 1'b1;
        req_in = 8'h21;
        tick();
        checks++;
        if (pending !== 8'h21) begin
            errors++;
            $display("FAIL two_latch: pending=%h, want 21", pending);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (cif.code_valid !== 1'b1 || cif.code !== want_code[k]) begin
                errors++;
                $display("FAIL two_present%0d: valid=%b code=%0d, want 1/%0d",
                         k, cif.code_valid, cif.code, want_code[k]);
            end
            tick();
            checks++;
            if (cif.code_valid !== 1'b0) begin
                errors++;
                $display("FAIL two_bubble%0d: valid=%b, want 0", k, cif.code_valid);
            end
        end
        checks++;
        if (pending !== 8'h00) begin
            errors++;
            $display("FAIL two_drained: pending=%h, want 00", pending);
        end
        req_in = '0;
        tick();
    endtask

    task automatic test_hold_stable();
        apply_reset();
        cif.code_ready = 1'b0;
        req_in = 8'h80;
        tick(); tick();
        for (int c = 0; c < 4; c++) begin
            mask[7] = ~mask[7];
            tick();
            checks++;
            if (cif.code_valid !== 1'b1 || cif.code !== 3'd7) begin
                errors++;
                $display("FAIL hold_stable cyc%0d: valid=%b code=%0d, want 1/7", c, cif.code_valid, cif.code);
            end
        end
        cif.code_ready = 1'b1;
        tick();
        checks++;
        if (cif.code_valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL hold_accept: valid=%b pending=%h, want 0/00", cif.code_valid, pending);
        end
        mask = '0; req_in = '0; cif.code_ready = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        apply_reset();
        cif.code_ready = 1'b0;
        req_in = 8'h80; tick();
        req_in = 8'h00; tick();
        req_in = 8'h80; tick();
        checks++;
        if (overflow !== OVF_EN || pending !== 8'h80) begin
            errors++;
            $display("FAIL overflow_set: ovf=%b pending=%h, want %b/80", overflow, pending, OVF_EN);
        end
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        checks++;
        if (overflow !== 1'b0 || pending !== 8'h00 || cif.code_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clr: ovf=%b pending=%h valid=%b, want 0/00/0",
                     overflow, pending, cif.code_valid);
        end
        req_in = '0;
        tick();
    endtask

    task automatic test_set_beats_ack();
        apply_reset();
        cif.code_ready = 1'b0;
        req_in = 8'h08; tick(); tick();
        req_in = 8'h00; tick();
        cif.code_ready = 1'b1;
        req_in = 8'h08;
        tick();
        checks++;
        if (cif.code_valid !== 1'b0 || pending !== 8'h08 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL setack_keep: valid=%b pending=%h ovf=%b, want 0/08/0",
                     cif.code_valid, pending, overflow);
        end
        req_in = 8'h00;
        tick();
        checks++;
        if (cif.code_valid !== 1'b1 || cif.code !== 3'd3) begin
            errors++;
            $display("FAIL setack_represent: valid=%b code=%0d, want 1/3", cif.code_valid, cif.code);
        end
        tick();
        checks++;
        if (pending !== 8'h00) begin
            errors++;
            $display("FAIL setack_drain: pending=%h, want 00", pending);
        end
    endtask

    task automatic test_mask_all();
        apply_reset();
        cif.code_ready = 1'b1;
        mask = 8'hFF;
        req_in = 8'h42;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (cif.code_valid !== 1'b0 || pending !== 8'h42) begin
            errors++;
            $display("FAIL mask_all: valid=%b pending=%h, want 0/42", cif.code_valid, pending);
        end
        mask = 8'hBF;
        tick();
        checks++;
        if (cif.code_valid !== 1'b1 || cif.code !== 3'd6) begin
            errors++;
            $display("FAIL mask_unmask: valid=%b code=%0d, want 1/6", cif.code_valid, cif.code);
        end
        mask = '0; req_in = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            rst_n          = ($urandom_range(0, 49) != 0);
            clr_all        = ($urandom_range(0, 24) == 0);
            req_in         = N'($urandom);
            mask           = N'($urandom & $urandom);
            cif.code_ready = ($urandom_range(0, 2) != 0);
            tick();
            checks++;
            if (cif.code_valid !== m_valid || pending !== m_pend || overflow !== m_ovf ||
                (m_valid && cif.code !== 3'(m_code))) begin
                errors++;
                $display("FAIL random cyc%0d: valid=%b code=%0d pending=%h ovf=%b, want %b/%0d/%h/%b",
                         c, cif.code_valid, cif.code, pending, overflow, m_valid, m_code, m_pend, m_ovf);
            end
        end
        rst_n = 1'b1; clr_all = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_in = '0; mask = '0; clr_all = 1'b0; cif.code_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_two_edges();
        test_hold_stable();
        test_overflow();
        test_set_beats_ack();
        test_mask_all();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
